// File: rtl/instr_fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch unit.
package instr_fetch_unit_pkg;

  localparam int unsigned InstrW   = 32;
  localparam logic [31:0] PcInc    = 32'd4;
  localparam logic [31:0] NopInstr = 32'h0000_0000;

  typedef enum logic [1:0] {
    StRun,
    StFlush,
    StHalt
  } fetch_state_e;

  typedef struct packed {
    logic [31:0]       pc;
    logic [InstrW-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_skid_fifo.sv
// Two-entry {pc, instr} skid buffer; entry 0 is the head and is presented directly.
module fetch_skid_fifo
  import instr_fetch_unit_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_push,
  input  logic         i_pop,
  input  logic         i_clear,
  input  fetch_entry_t i_data,
  output fetch_entry_t o_head,
  output logic [1:0]   o_occ
);

  localparam fetch_entry_t EmptyEntry = '{pc: 32'h0, instr: NopInstr};

  fetch_entry_t r_ent0, r_ent1, w_ent0, w_ent1;
  logic [1:0]   r_occ, w_occ;

  assign o_head = r_ent0;
  assign o_occ  = r_occ;

  always_comb begin
    w_ent0 = r_ent0;
    w_ent1 = r_ent1;
    w_occ  = r_occ;
    // Clear wins over push/pop: the popped entry has already been consumed.
    if (i_clear) begin
      w_occ = 2'd0;
    end else begin
      unique case ({i_push, i_pop})
        2'b10: begin
          if (r_occ == 2'd0) w_ent0 = i_data;
          else               w_ent1 = i_data;
          w_occ = r_occ + 2'd1;
        end
        2'b01: begin
          w_ent0 = r_ent1;
          w_occ  = r_occ - 2'd1;
        end
        2'b11: begin
          if (r_occ == 2'd1) begin
            w_ent0 = i_data;
          end else begin
            w_ent0 = r_ent1;
            w_ent1 = i_data;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ent0 <= EmptyEntry;
      r_ent1 <= EmptyEntry;
      r_occ  <= 2'd0;
    end else begin
      r_ent0 <= w_ent0;
      r_ent1 <= w_ent1;
      r_occ  <= w_occ;
    end
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch: owns the PC, reads a synchronous imem, and hands words to decode.
module instr_fetch_unit
  import instr_fetch_unit_pkg::*;
#(
  parameter int unsigned ADDR_W   = 10,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              imem_en,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [31:0]       imem_rdata,
  output logic [31:0]       instr,
  output logic [31:0]       instr_pc,
  output logic              instr_valid,
  input  logic              instr_ready,
  input  logic              redirect,
  input  logic [31:0]       redirect_pc,
  input  logic              halt
);

  fetch_state_e r_state, w_state_next;
  logic [31:0]  r_fetch_pc, w_fetch_pc_next;
  logic [31:0]  r_inflight_pc;
  logic         r_inflight;
  logic [1:0]   w_occ, w_level;
  logic         w_transfer, w_room, w_issue, w_push;
  fetch_entry_t w_head, w_push_data;

  assign instr_valid = (w_occ != 2'd0);
  assign instr       = w_head.instr;
  assign instr_pc    = w_head.pc;
  assign w_transfer  = instr_valid & instr_ready;

  // Occupancy plus outstanding read never exceeds the two buffer slots.
  assign w_level = w_occ + {1'b0, r_inflight};
  assign w_room  = (w_level <= 2'd1) | ((w_level == 2'd2) & w_transfer);
  // Gated by rst_n so the strobe drops the moment reset asserts.
  assign w_issue = rst_n & ~redirect & ~halt & w_room;

  assign imem_en   = w_issue;
  assign imem_addr = r_fetch_pc[ADDR_W+1:2];

  // Data for a read launched before a redirect is stale and never enters the buffer.
  assign w_push      = r_inflight & (r_state != StFlush);
  assign w_push_data = '{pc: r_inflight_pc, instr: imem_rdata};

  always_comb begin
    w_state_next    = StRun;
    w_fetch_pc_next = r_fetch_pc;
    if (redirect)  w_state_next = StFlush;
    else if (halt) w_state_next = StHalt;
    if (redirect) begin
      w_fetch_pc_next = redirect_pc & ~32'h3;
    end else if (w_issue) begin
      w_fetch_pc_next = r_fetch_pc + PcInc;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= StRun;
      r_fetch_pc    <= RESET_PC;
      r_inflight    <= 1'b0;
      r_inflight_pc <= 32'h0;
    end else begin
      r_state    <= w_state_next;
      r_fetch_pc <= w_fetch_pc_next;
      r_inflight <= w_issue;
      if (w_issue) r_inflight_pc <= r_fetch_pc;
    end
  end

  fetch_skid_fifo u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_pop   (w_transfer),
    .i_clear (redirect),
    .i_data  (w_push_data),
    .o_head  (w_head),
    .o_occ   (w_occ)
  );

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Randomized bench for instr_fetch_unit against a transaction-level delivery model.
module tb_instr_fetch_unit;

  localparam int unsigned ADDR_W   = 10;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              imem_en;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_rdata = 32'h0;
  logic [31:0]       instr, instr_pc;
  logic              instr_valid;
  logic              instr_ready = 1'b1;
  logic              redirect = 1'b0;
  logic [31:0]       redirect_pc = 32'h0;
  logic              halt = 1'b0;

  instr_fetch_unit #(
    .ADDR_W   (ADDR_W),
    .RESET_PC (RESET_PC)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .imem_en     (imem_en),
    .imem_addr   (imem_addr),
    .imem_rdata  (imem_rdata),
    .instr       (instr),
    .instr_pc    (instr_pc),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .halt        (halt)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [1 << ADDR_W];

  always @(posedge clk) begin
    if (imem_en) imem_rdata <= mem[imem_addr];
  end

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  // Model: the ordered stream of PCs decode must receive.
  logic [31:0] exp_pc;
  logic        hold_prev;
  logic [31:0] hold_pc, hold_instr;
  int unsigned run_cnt, halt_rdy_cnt;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    exp_pc       = RESET_PC;
    hold_prev    = 1'b0;
    hold_pc      = 32'h0;
    hold_instr   = 32'h0;
    run_cnt      = 0;
    halt_rdy_cnt = 0;
  endtask

  task automatic model_cycle();
    logic [31:0] idx_pc;
    logic        run_now;
    run_now = instr_ready & ~halt & ~redirect;
    if (halt_rdy_cnt >= 2) check_eq("halt_drained", {31'b0, instr_valid}, 32'd0);
    if (run_cnt >= 2 && run_now) check_eq("throughput", {31'b0, instr_valid}, 32'd1);
    if (hold_prev) begin
      check_eq("hold_valid", {31'b0, instr_valid}, 32'd1);
      check_eq("hold_pc", instr_pc, hold_pc);
      check_eq("hold_instr", instr, hold_instr);
    end
    if (halt || redirect) check_eq("no_issue", {31'b0, imem_en}, 32'd0);
    if (instr_valid && instr_ready) begin
      idx_pc = exp_pc;
      check_eq("xfer_pc", instr_pc, exp_pc);
      check_eq("xfer_instr", instr, mem[idx_pc[ADDR_W+1:2]]);
      exp_pc = exp_pc + 32'd4;
    end
    if (redirect) exp_pc = redirect_pc & ~32'h3;
    hold_prev    = instr_valid & ~instr_ready & ~redirect;
    hold_pc      = instr_pc;
    hold_instr   = instr;
    run_cnt      = run_now ? run_cnt + 1 : 0;
    halt_rdy_cnt = (halt && instr_ready) ? halt_rdy_cnt + 1 : 0;
  endtask

  task automatic step(input logic rdy, input logic hlt, input logic redir, input logic [31:0] rpc);
    @(negedge clk);
    instr_ready = rdy;
    halt        = hlt;
    redirect    = redir;
    redirect_pc = rpc;
    #1;
    model_cycle();
  endtask

  task automatic do_reset();
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check_eq("rst_async_valid", {31'b0, instr_valid}, 32'd0);
    check_eq("rst_async_en", {31'b0, imem_en}, 32'd0);
    instr_ready = 1'b1;
    halt        = 1'b0;
    redirect    = 1'b0;
    @(negedge clk);
    #1;
    check_eq("rst_instr", instr, 32'h0);
    check_eq("rst_pc", instr_pc, 32'h0);
    check_eq("rst_addr", {22'b0, imem_addr}, {22'b0, RESET_PC[ADDR_W+1:2]});
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    model_reset();
  endtask

  initial begin
    logic seen;
    for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = $urandom;
    mem[0] = 32'h0022_1820;
    mem[1] = 32'hAC21_0002;
    model_reset();

    // Reset, then streaming with decode always ready.
    do_reset();
    step(1'b1, 1'b0, 1'b0, 32'h0);
    check_eq("first_issue", {31'b0, imem_en}, 32'd1);
    step(1'b1, 1'b0, 1'b0, 32'h0);
    step(1'b1, 1'b0, 1'b0, 32'h0);
    check_eq("first_valid", {31'b0, instr_valid}, 32'd1);
    check_eq("first_instr", instr, 32'h0022_1820);
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 1'b0, 32'h0);

    // Mid-stream async reset, then backpressure right after first valid.
    do_reset();
    step(1'b1, 1'b0, 1'b0, 32'h0);
    step(1'b1, 1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b0, 32'h0);
    check_eq("bp_en", {31'b0, imem_en}, 32'd0);
    check_eq("bp_pc", instr_pc, 32'h0);
    for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 1'b0, 32'h0);

    // Redirect with a full buffer; low address bits are discarded.
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b0, 1'b1, 32'h0000_0043);
    seen = 1'b0;
    for (int i = 0; i < 6 && !seen; i++) begin
      step(1'b1, 1'b0, 1'b0, 32'h0);
      seen = instr_valid;
    end
    check_eq("redir_seen", {31'b0, seen}, 32'd1);
    check_eq("redir_pc", instr_pc, 32'h0000_0040);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b0, 32'h0);

    // Redirect coinciding with a transfer.
    step(1'b1, 1'b0, 1'b1, 32'h0000_0200);
    for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 1'b0, 32'h0);

    // Halt for four cycles mid-stream.
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b0, 32'h0);
    check_eq("halt_idle", {31'b0, instr_valid}, 32'd0);
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 1'b0, 32'h0);

    // 32-bit PC wrap.
    step(1'b1, 1'b0, 1'b1, 32'hFFFF_FFF8);
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 1'b0, 32'h0);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      step(($urandom % 4) != 0, ($urandom % 6) == 0, ($urandom % 16) == 0, $urandom);
    end
    do_reset();
    for (int i = 0; i < 200; i++) begin
      step(($urandom % 3) != 0, ($urandom % 8) == 0, ($urandom % 20) == 0, $urandom);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
